// File: rtl/wb_slave_pkg.sv
// Shared types and address-map defaults for the Wishbone slave bridge.
package wb_slave_pkg;

  localparam int DATA_W_DEF      = 128;
  localparam int ADR_W_DEF       = 5;
  localparam int NUM_REGS_DEF    = 16;
  localparam int CMD_ADR_DEF     = 16;
  localparam int FIFO_WR_ADR_DEF = 17;
  localparam int FIFO_RD_ADR_DEF = 18;
  localparam int DAT_ADR_DEF     = 19;
  localparam int TIMEOUT_CYC_DEF = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_STALL,
    ST_EXEC,
    ST_WAIT,
    ST_ACKX,
    ST_ERR
  } state_t;

  typedef enum logic [2:0] {
    K_REG_RD,
    K_REG_WR,
    K_FIFO_RD,
    K_FIFO_WR,
    K_CMD,
    K_DAT,
    K_BAD
  } kind_t;

endpackage

// File: rtl/wb_addr_decoder.sv
// Combinational classification of a Wishbone address/direction into an access kind.
module wb_addr_decoder
  import wb_slave_pkg::*;
#(
  parameter int ADR_W       = ADR_W_DEF,
  parameter int NUM_REGS    = NUM_REGS_DEF,
  parameter int CMD_ADR     = CMD_ADR_DEF,
  parameter int FIFO_WR_ADR = FIFO_WR_ADR_DEF,
  parameter int FIFO_RD_ADR = FIFO_RD_ADR_DEF,
  parameter int DAT_ADR     = DAT_ADR_DEF
) (
  input  logic [ADR_W-1:0] i_adr,
  input  logic             i_we,
  output kind_t            o_kind
);

  always_comb begin
    o_kind = K_BAD;
    if (32'(i_adr) < 32'(NUM_REGS)) begin
      o_kind = i_we ? K_REG_WR : K_REG_RD;
    end else if (i_adr == ADR_W'(FIFO_WR_ADR)) begin
      o_kind = i_we ? K_FIFO_WR : K_BAD;
    end else if (i_adr == ADR_W'(FIFO_RD_ADR)) begin
      o_kind = i_we ? K_BAD : K_FIFO_RD;
    end else if (i_adr == ADR_W'(CMD_ADR)) begin
      o_kind = i_we ? K_CMD : K_BAD;
    end else if (i_adr == ADR_W'(DAT_ADR)) begin
      o_kind = i_we ? K_DAT : K_BAD;
    end
  end

endmodule

// File: rtl/wb_slave_bridge.sv
// Wishbone classic slave in front of the SD host core (regs, data FIFO, CMD/DAT exec).
// Optional exec wait timeout enabled by defining WB_EXEC_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for cyc_i & strobe; latches address, data and access kind
// ACCESS | one-cycle reg/FIFO access with ack_o
// STALL  | FIFO full (write) or empty (read); holds until the flag clears
// EXEC   | one-cycle new_command / new_data launch
// WAIT   | waiting for the done pulse that matches the launched exec
// ACKX   | one-cycle ack_o closing an exec
// ERR    | one-cycle error_o for an unmapped address or wrong direction
module wb_slave_bridge
  import wb_slave_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADR_W       = ADR_W_DEF,
  parameter int NUM_REGS    = NUM_REGS_DEF,
  parameter int CMD_ADR     = CMD_ADR_DEF,
  parameter int FIFO_WR_ADR = FIFO_WR_ADR_DEF,
  parameter int FIFO_RD_ADR = FIFO_RD_ADR_DEF,
  parameter int DAT_ADR     = DAT_ADR_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cyc_i,
  input  logic              strobe,
  input  logic              we_i,
  input  logic [ADR_W-1:0]  adr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic [DATA_W-1:0] wb_data_o,
  output logic              ack_o,
  output logic              error_o,
  input  logic [DATA_W-1:0] host_data_i,
  input  logic              cmd_done_i,
  input  logic              data_done_i,
  input  logic              fifo_full_i,
  input  logic              fifo_empty_i,
  output logic [DATA_W-1:0] host_data_o,
  output logic [ADR_W-1:0]  adr_o,
  output logic              reg_read_en,
  output logic              reg_write_en,
  output logic              fifo_read_en,
  output logic              fifo_write_en,
  output logic              new_command,
  output logic              new_data,
  output logic              busy_o
);

  if (TIMEOUT_CYC < 1) begin : g_timeout_chk
    $error("wb_slave_bridge: TIMEOUT_CYC must be at least 1");
  end

  state_t              r_state;
  state_t              w_next;
  kind_t               w_kind;
  kind_t               r_kind;
  logic [ADR_W-1:0]    r_adr;
  logic [DATA_W-1:0]   r_data;
  logic                w_accept;
  logic                w_blocked;
  logic                w_done;
  logic                w_timeout;
  logic                w_access;
  logic                w_exec;

  wb_addr_decoder #(
    .ADR_W       (ADR_W),
    .NUM_REGS    (NUM_REGS),
    .CMD_ADR     (CMD_ADR),
    .FIFO_WR_ADR (FIFO_WR_ADR),
    .FIFO_RD_ADR (FIFO_RD_ADR),
    .DAT_ADR     (DAT_ADR)
  ) u_decoder (
    .i_adr  (adr_i),
    .i_we   (we_i),
    .o_kind (w_kind)
  );

  assign w_accept  = cyc_i & strobe;
  assign w_blocked = (r_kind == K_FIFO_WR) ? fifo_full_i : fifo_empty_i;
  assign w_done    = (r_kind == K_CMD) ? cmd_done_i : data_done_i;

`ifdef WB_EXEC_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] r_cnt;

  // Loaded while launching so WAIT lasts exactly TIMEOUT_CYC cycles before ERR.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (r_state == ST_EXEC) begin
      r_cnt <= CNT_W'(TIMEOUT_CYC - 1);
    end else if (r_state == ST_WAIT && r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign w_timeout = (r_cnt == '0);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_kind  <= K_BAD;
      r_adr   <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && w_accept) begin
        r_kind <= w_kind;
        r_adr  <= adr_i;
        r_data <= wb_data_i;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          case (w_kind)
            K_REG_RD, K_REG_WR: w_next = ST_ACCESS;
            K_FIFO_RD:          w_next = fifo_empty_i ? ST_STALL : ST_ACCESS;
            K_FIFO_WR:          w_next = fifo_full_i ? ST_STALL : ST_ACCESS;
            K_CMD, K_DAT:       w_next = ST_EXEC;
            default:            w_next = ST_ERR;
          endcase
        end
      end
      ST_STALL: begin
        if (!cyc_i)          w_next = ST_IDLE;
        else if (!w_blocked) w_next = ST_ACCESS;
      end
      ST_EXEC: w_next = ST_WAIT;
      // Master abandoning the cycle wins over a late done; the exec itself keeps running.
      ST_WAIT: begin
        if (!cyc_i)         w_next = ST_IDLE;
        else if (w_done)    w_next = ST_ACKX;
        else if (w_timeout) w_next = ST_ERR;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_access = (r_state == ST_ACCESS);
  assign w_exec   = (r_state == ST_EXEC);

  assign ack_o         = w_access | (r_state == ST_ACKX);
  assign error_o       = (r_state == ST_ERR);
  assign busy_o        = (r_state == ST_STALL) | w_exec | (r_state == ST_WAIT);
  assign reg_read_en   = w_access & (r_kind == K_REG_RD);
  assign reg_write_en  = w_access & (r_kind == K_REG_WR);
  assign fifo_read_en  = w_access & (r_kind == K_FIFO_RD);
  assign fifo_write_en = w_access & (r_kind == K_FIFO_WR);
  assign new_command   = w_exec & (r_kind == K_CMD);
  assign new_data      = w_exec & (r_kind == K_DAT);
  assign wb_data_o     = (reg_read_en | fifo_read_en) ? host_data_i : '0;
  assign host_data_o   = r_data;
  assign adr_o         = r_adr;

endmodule
